// File: rtl/sha_job_pkg.sv
// Shared types and constants for the job deframer: payload layout, FSM states,
// and the decoded job record with its payload-to-field mapping.
package sha_job_pkg;

   localparam logic [7:0] SOF_DEFAULT   = 8'hA5;
   localparam int         PAYLOAD_BYTES = 84;
   localparam int         DATA_OFS      = 0;
   localparam int         STATE_OFS     = 12;
   localparam int         TARGET_OFS    = 44;
   localparam int         NONCE_OFS     = 76;
   localparam int         POS_OFS       = 80;

   typedef enum logic [1:0] {HUNT, PAYLOAD, CSUM, HOLD} deframe_state_t;

   typedef logic [PAYLOAD_BYTES-1:0][7:0] payload_t;

   typedef struct packed {
      logic [11:0][7:0] data;
      logic [7:0][31:0] state;
      logic [31:0][7:0] target;
      logic [31:0]      nonce;
      logic [31:0]      pos;
   } sha_job_t;

   // Midstate words are big-endian; nonce and position are little-endian.
   function automatic sha_job_t unpack_job(input payload_t p);
      sha_job_t j;
      for (int k = 0; k < 12; k++) j.data[k] = p[DATA_OFS+k];
      for (int i = 0; i < 8; i++)
         j.state[i] = {p[STATE_OFS+4*i], p[STATE_OFS+4*i+1],
                       p[STATE_OFS+4*i+2], p[STATE_OFS+4*i+3]};
      for (int k = 0; k < 32; k++) j.target[k] = p[TARGET_OFS+k];
      j.nonce = {p[NONCE_OFS+3], p[NONCE_OFS+2], p[NONCE_OFS+1], p[NONCE_OFS]};
      j.pos   = {p[POS_OFS+3], p[POS_OFS+2], p[POS_OFS+1], p[POS_OFS]};
      return j;
   endfunction

endpackage

// File: rtl/sha_job_deframer.sv
// Byte-stream deframer: hunts SOF, stages an 84-byte payload, verifies the XOR
// checksum and holds the decoded job on a valid/ready port until it is taken.
module sha_job_deframer
   import sha_job_pkg::*;
#(
   parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
   parameter int         TIMEOUT_CYCLES = 100_000
) (
   input  logic                clk,
   input  logic                in_rst,
   input  logic                in_byte_valid,
   input  logic [7:0]          in_byte_data,
   output logic                out_byte_ready,
   output logic                out_job_valid,
   input  logic                in_job_ready,
   output logic [11:0][7:0]    out_job_data,
   output logic [7:0][31:0]    out_job_state,
   output logic [31:0][7:0]    out_job_target,
   output logic [31:0]         out_job_nonce,
   output logic [31:0]         out_job_pos,
   output logic                out_err_csum,
   output logic                out_err_tmo
);

   localparam int            TW       = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [6:0]    CNT_LAST = 7'(PAYLOAD_BYTES - 1);

   deframe_state_t state_q, state_d;
   logic [6:0]     cnt_q, cnt_d;
   logic [7:0]     csum_q, csum_d;
   logic [TW-1:0]  timer_q, timer_d;
   payload_t       stage_q, stage_d;
   sha_job_t       job_q, job_d;
   logic           valid_q, valid_d;
   logic           err_csum_q, err_csum_d;
   logic           err_tmo_q, err_tmo_d;
   logic           accept;
   logic           stage_we;

   assign out_byte_ready = (state_q != HOLD);
   assign accept         = in_byte_valid & out_byte_ready;

   // Only the byte addressed by the payload counter is rewritten.
   for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_stage
      assign stage_d[gi] = (stage_we && cnt_q == 7'(gi)) ? in_byte_data : stage_q[gi];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      csum_d     = csum_q;
      timer_d    = timer_q;
      job_d      = job_q;
      valid_d    = valid_q;
      err_csum_d = 1'b0;
      err_tmo_d  = 1'b0;
      stage_we   = 1'b0;

      case (state_q)
         HUNT: begin
            if (accept && in_byte_data == SOF_BYTE) begin
               state_d = PAYLOAD;
               cnt_d   = '0;
               csum_d  = '0;
               timer_d = '0;
            end
         end
         PAYLOAD, CSUM: begin
            if (accept) begin
               timer_d = '0;
               if (state_q == PAYLOAD) begin
                  stage_we = 1'b1;
                  csum_d   = csum_q ^ in_byte_data;
                  cnt_d    = cnt_q + 7'd1;
                  if (cnt_q == CNT_LAST) state_d = CSUM;
               end else if (in_byte_data == csum_q) begin
                  job_d   = unpack_job(stage_q);
                  valid_d = 1'b1;
                  state_d = HOLD;
               end else begin
                  err_csum_d = 1'b1;
                  state_d    = HUNT;
               end
            end else if (timer_q == TMO_LAST) begin
               err_tmo_d = 1'b1;
               state_d   = HUNT;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         HOLD: begin
            if (in_job_ready) begin
               valid_d = 1'b0;
               state_d = HUNT;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge clk or posedge in_rst) begin
      if (in_rst) begin
         state_q    <= HUNT;
         cnt_q      <= '0;
         csum_q     <= '0;
         timer_q    <= '0;
         stage_q    <= '0;
         job_q      <= '0;
         valid_q    <= 1'b0;
         err_csum_q <= 1'b0;
         err_tmo_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         csum_q     <= csum_d;
         timer_q    <= timer_d;
         stage_q    <= stage_d;
         job_q      <= job_d;
         valid_q    <= valid_d;
         err_csum_q <= err_csum_d;
         err_tmo_q  <= err_tmo_d;
      end
   end

   assign out_job_valid  = valid_q;
   assign out_job_data   = job_q.data;
   assign out_job_state  = job_q.state;
   assign out_job_target = job_q.target;
   assign out_job_nonce  = job_q.nonce;
   assign out_job_pos    = job_q.pos;
   assign out_err_csum   = err_csum_q;
   assign out_err_tmo    = err_tmo_q;

endmodule

// File: tb/tb_sha_job_deframer.sv
// Self-checking bench for sha_job_deframer: table of frame vectors, randomized
// frames, and hand-written timeout / hold / reset sequences against a byte model.
module tb_sha_job_deframer;
   import sha_job_pkg::*;

   localparam int TMO = 50;

   logic             clk = 1'b0;
   logic             in_rst;
   logic             in_byte_valid;
   logic [7:0]       in_byte_data;
   logic             out_byte_ready;
   logic             out_job_valid;
   logic             in_job_ready;
   logic [11:0][7:0] out_job_data;
   logic [7:0][31:0] out_job_state;
   logic [31:0][7:0] out_job_target;
   logic [31:0]      out_job_nonce;
   logic [31:0]      out_job_pos;
   logic             out_err_csum;
   logic             out_err_tmo;

   sha_job_deframer #(.SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .in_rst(in_rst),
      .in_byte_valid(in_byte_valid), .in_byte_data(in_byte_data),
      .out_byte_ready(out_byte_ready), .out_job_valid(out_job_valid),
      .in_job_ready(in_job_ready), .out_job_data(out_job_data),
      .out_job_state(out_job_state), .out_job_target(out_job_target),
      .out_job_nonce(out_job_nonce), .out_job_pos(out_job_pos),
      .out_err_csum(out_err_csum), .out_err_tmo(out_err_tmo)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] pl   [PAYLOAD_BYTES];
   logic [7:0] good [PAYLOAD_BYTES];

   typedef struct {
      int         pattern;
      logic [7:0] flip;
      int         n_gar;
      int         hold;
      bit         exp_valid;
   } vec_t;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] be_word(input int o);
      return (32'(good[o]) << 24) | (32'(good[o+1]) << 16) | (32'(good[o+2]) << 8) | 32'(good[o+3]);
   endfunction

   function automatic logic [31:0] le_word(input int o);
      return 32'(good[o]) + (32'(good[o+1]) << 8) + (32'(good[o+2]) << 16) + (32'(good[o+3]) << 24);
   endfunction

   task automatic check_job(input string name);
      logic [95:0]  d;
      logic [255:0] s;
      logic [255:0] t;
      for (int k = 0; k < 12; k++) d[k*8 +: 8] = good[k];
      for (int i = 0; i < 8; i++)  s[i*32 +: 32] = be_word(STATE_OFS + 4*i);
      for (int k = 0; k < 32; k++) t[k*8 +: 8] = good[TARGET_OFS + k];
      chk({name, ".data"},   256'(out_job_data),   256'(d));
      chk({name, ".state"},  256'(out_job_state),  s);
      chk({name, ".target"}, 256'(out_job_target), t);
      chk({name, ".nonce"},  256'(out_job_nonce),  256'(le_word(NONCE_OFS)));
      chk({name, ".pos"},    256'(out_job_pos),    256'(le_word(POS_OFS)));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_byte_valid = 1'b1;
      in_byte_data  = b;
      while (!out_byte_ready && n < 1000) begin
         tick();
         n++;
      end
      if (n >= 1000) begin
         checks++;
         errors++;
         $display("FAIL send_byte_wait actual=ready_low required=ready_high");
      end
      tick();
      in_byte_valid = 1'b0;
   endtask

   task automatic clear_model();
      foreach (good[k]) good[k] = 8'h00;
   endtask

   task automatic do_reset_async(input string name);
      #3 in_rst = 1'b1;
      #1;
      clear_model();
      chk({name, ".valid"}, 256'(out_job_valid), 256'(0));
      chk({name, ".ready"}, 256'(out_byte_ready), 256'(1));
      chk({name, ".errs"},  256'({out_err_csum, out_err_tmo}), 256'(0));
      check_job(name);
      #2 in_rst = 1'b0;
      tick();
   endtask

   task automatic fill_payload(input int pattern, output logic [7:0] cs);
      cs = 8'h00;
      for (int k = 0; k < PAYLOAD_BYTES; k++) begin
         pl[k] = (pattern == 0) ? 8'(k) : 8'($urandom);
         cs ^= pl[k];
      end
   endtask

   task automatic send_frame(input string name, input int pattern, input logic [7:0] flip,
                             input int n_gar, input int hold, input bit exp_valid,
                             input bit rst_hold);
      logic [7:0] cs;
      logic [7:0] gar [4];
      bit ok;
      gar = '{8'h00, 8'h55, 8'hFF, 8'h3C};
      fill_payload(pattern, cs);
      for (int g = 0; g < n_gar; g++) send_byte(gar[g % 4]);
      send_byte(8'hA5);
      for (int k = 0; k < PAYLOAD_BYTES; k++) send_byte(pl[k]);
      in_job_ready = 1'b0;
      send_byte(cs ^ flip);
      if (exp_valid) begin
         good = pl;
         chk({name, ".valid"}, 256'(out_job_valid), 256'(1));
         check_job(name);
         if (hold > 0) begin
            ok = 1'b1;
            for (int c = 0; c < hold; c++) begin
               in_byte_valid = 1'b1;
               in_byte_data  = 8'($urandom_range(0, 8'hA4));
               tick();
               if (!(out_job_valid === 1'b1 && out_byte_ready === 1'b0 &&
                     out_job_nonce === le_word(NONCE_OFS) && out_job_pos === le_word(POS_OFS) &&
                     out_job_state[7] === be_word(STATE_OFS + 28))) ok = 1'b0;
            end
            in_byte_valid = 1'b0;
            chk({name, ".hold_stable"}, 256'(ok), 256'(1));
         end
         if (rst_hold) begin
            do_reset_async({name, ".rst_hold"});
         end else begin
            in_job_ready = 1'b1;
            tick();
            in_job_ready = 1'b0;
            chk({name, ".valid_drop"}, 256'(out_job_valid), 256'(0));
         end
      end else begin
         chk({name, ".err_csum"}, 256'(out_err_csum), 256'(1));
         chk({name, ".no_valid"}, 256'(out_job_valid), 256'(0));
         check_job({name, ".kept"});
         tick();
         chk({name, ".err_csum_end"}, 256'(out_err_csum), 256'(0));
      end
      $display("frame %s: flip=%0h garbage=%0d hold=%0d valid_expected=%0d", name, flip, n_gar, hold, exp_valid);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs [7];
      logic [7:0] cs;
      logic [7:0] flip;
      bit ok;

      vecs = '{
         '{0, 8'h00, 0, 0, 1'b1},
         '{0, 8'h01, 0, 0, 1'b0},
         '{0, 8'h00, 0, 0, 1'b1},
         '{0, 8'h00, 3, 0, 1'b1},
         '{1, 8'h00, 1, 2, 1'b1},
         '{1, 8'h80, 2, 0, 1'b0},
         '{1, 8'h00, 0, 5, 1'b1}
      };

      in_rst = 1'b1;
      in_byte_valid = 1'b0;
      in_byte_data = 8'h00;
      in_job_ready = 1'b0;
      clear_model();
      #1;
      chk("reset.valid", 256'(out_job_valid), 256'(0));
      chk("reset.ready", 256'(out_byte_ready), 256'(1));
      chk("reset.errs",  256'({out_err_csum, out_err_tmo}), 256'(0));
      check_job("reset");
      repeat (2) @(posedge clk);
      #3 in_rst = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) begin
         send_frame($sformatf("vec%0d", i), vecs[i].pattern, vecs[i].flip, vecs[i].n_gar,
                    vecs[i].hold, vecs[i].exp_valid, 1'b0);
         if (i == 0 || i == 3) begin
            chk($sformatf("vec%0d.state0_const", i), 256'(out_job_state[0]), 256'(32'h0C0D0E0F));
            chk($sformatf("vec%0d.nonce_const", i),  256'(out_job_nonce),    256'(32'h4F4E4D4C));
            chk($sformatf("vec%0d.pos_const", i),    256'(out_job_pos),      256'(32'h53525150));
         end
      end

      for (int r = 0; r < 6; r++) begin
         flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         send_frame($sformatf("rnd%0d", r), 1, flip, $urandom_range(0, 3),
                    $urandom_range(0, 4), flip == 8'h00, 1'b0);
      end

      // Stall after 40 payload bytes: the timeout must fire on idle cycle 50 only.
      send_byte(8'hA5);
      for (int k = 0; k < 40; k++) send_byte(8'(k));
      ok = 1'b1;
      for (int c = 1; c < TMO; c++) begin
         tick();
         if (out_err_tmo !== 1'b0 || out_job_valid !== 1'b0) ok = 1'b0;
      end
      chk("tmo.quiet_before", 256'(ok), 256'(1));
      tick();
      chk("tmo.pulse", 256'(out_err_tmo), 256'(1));
      tick();
      chk("tmo.pulse_end", 256'(out_err_tmo), 256'(0));
      $display("timeout sequence: pulse after %0d idle cycles", TMO);
      send_frame("after_tmo", 0, 8'h00, 0, 0, 1'b1, 1'b0);

      // Byte arriving on the last idle cycle beats the timeout.
      fill_payload(1, cs);
      send_byte(8'hA5);
      for (int k = 0; k < 40; k++) send_byte(pl[k]);
      ok = 1'b1;
      for (int c = 1; c < TMO; c++) begin
         tick();
         if (out_err_tmo !== 1'b0) ok = 1'b0;
      end
      send_byte(pl[40]);
      if (out_err_tmo !== 1'b0) ok = 1'b0;
      chk("tmo_edge.no_pulse", 256'(ok), 256'(1));
      for (int k = 41; k < PAYLOAD_BYTES; k++) send_byte(pl[k]);
      send_byte(cs);
      good = pl;
      chk("tmo_edge.valid", 256'(out_job_valid), 256'(1));
      check_job("tmo_edge");
      in_job_ready = 1'b1;
      tick();
      in_job_ready = 1'b0;
      $display("timeout edge sequence: byte on last idle cycle accepted");

      send_frame("long_hold", 1, 8'h00, 0, 200, 1'b1, 1'b0);
      send_frame("after_hold", 1, 8'h00, 0, 0, 1'b1, 1'b0);

      // Reset in the middle of a payload, then while a job is held.
      fill_payload(1, cs);
      send_byte(8'hA5);
      for (int k = 0; k < 30; k++) send_byte(pl[k]);
      do_reset_async("rst_mid");
      $display("reset mid-frame at payload byte 30");
      send_frame("after_rst_mid", 0, 8'h00, 0, 0, 1'b1, 1'b0);
      send_frame("rst_in_hold", 1, 8'h00, 0, 3, 1'b1, 1'b1);
      send_frame("after_rst_hold", 1, 8'h00, 1, 0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
